ram_copy_master: RTL and testbench

Block-copy initiator that drives one port of the multiport data RAM (registered read, one-cycle latency, write-first on same-port access). On a start pulse it reads `length` words from a source region and writes them to a destination region, one word every two cycles, then pulses `done`. It sits beside the processor core as a memory-to-memory move engine and owns one RAM port slice (address, datain, mem_write, dataout) exclusively.

---
 rtl/ram_copy_master.sv | 94 +++++++++
 tb/tb_ram_copy_master.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ram_copy_master.sv
// rtl/ram_copy_master.sv - ascending block copy between two regions of one RAM port
// Reads one word, writes it back one cycle later; two cycles per word.
module ram_copy_master #(
  parameter int mem_width  = 12,
  parameter int addr_width = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [addr_width-1:0] src_addr,
  input  logic [addr_width-1:0] dst_addr,
  input  logic [addr_width:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [addr_width-1:0] ram_address,
  output logic [mem_width-1:0]  ram_datain,
  output logic                  ram_mem_write,
  input  logic [mem_width-1:0]  ram_dataout
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  localparam logic [addr_width-1:0] addr_one = 1;
  localparam logic [addr_width:0]   rem_one  = 1;

  state_t                state;
  logic [addr_width-1:0] src;
  logic [addr_width-1:0] dst;
  logic [addr_width:0]   remaining;

  // RAM read data is registered, so during WR it already holds the word read in RD
  assign ram_datain = (state == WR) ? ram_dataout : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      src           <= '0;
      dst           <= '0;
      remaining     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      ram_address   <= '0;
      ram_mem_write <= 1'b0;
    end else begin
      done          <= 1'b0;
      ram_mem_write <= 1'b0;
      ram_address   <= '0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start) begin
            src       <= src_addr;
            dst       <= dst_addr;
            remaining <= length;
            busy      <= 1'b1;
            if (length == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state       <= RD;
              ram_address <= src_addr;
            end
          end
        end
        RD: begin
          state         <= WR;
          ram_address   <= dst;
          ram_mem_write <= 1'b1;
        end
        WR: begin
          src       <= src + addr_one;
          dst       <= dst + addr_one;
          remaining <= remaining - rem_one;
          if (remaining == rem_one) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state       <= RD;
            ram_address <= src + addr_one;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_copy_master.sv
// tb/tb_ram_copy_master.sv - scoreboard bench for ram_copy_master with a RAM model
// Expected writes come from a sequential array-copy reference; a monitor pops them.
module tb_ram_copy_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [11:0] src_addr = '0;
  logic [11:0] dst_addr = '0;
  logic [12:0] length = '0;
  logic        busy, done, ram_mem_write;
  logic [11:0] ram_address, ram_datain, ram_dataout;

  logic [11:0] mem [4096];
  logic [11:0] ref_mem [4096];
  logic        pl_we = 1'b0;
  logic [11:0] pl_addr = '0, pl_data = '0;

  typedef struct {logic [11:0] a; logic [11:0] d;} wr_t;
  wr_t exp_q[$];

  int checks = 0;
  int errors = 0;
  bit prev_we = 1'b0;

  always #5 clk = ~clk;

  ram_copy_master #(.mem_width(12), .addr_width(12)) dut (
    .clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .length(length), .busy(busy), .done(done), .ram_address(ram_address),
    .ram_datain(ram_datain), .ram_mem_write(ram_mem_write), .ram_dataout(ram_dataout)
  );

  // Registered-read RAM, write-first on the copy port; pl_* is a bench-only preload path
  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (ram_mem_write) mem[ram_address] <= ram_datain;
    ram_dataout <= ram_mem_write ? ram_datain : mem[ram_address];
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (ram_mem_write) begin
        wr_t e;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write addr=%h data=%h required no write", ram_address, ram_datain);
        end else begin
          e = exp_q.pop_front();
          if (ram_address !== e.a || ram_datain !== e.d) begin
            errors++;
            $display("FAIL write addr=%h data=%h required addr=%h data=%h", ram_address, ram_datain, e.a, e.d);
          end
        end
        checks++;
        if (prev_we) begin
          errors++;
          $display("FAIL back_to_back_write got two consecutive write cycles required one");
        end
      end
      prev_we = ram_mem_write;
    end else prev_we = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [11:0] v);
    @(negedge clk);
    pl_we = 1'b1; pl_addr = a; pl_data = v;
    ref_mem[a] = v;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic run_copy(input logic [11:0] s, input logic [11:0] d, input int l, input bit ign);
    int last;
    int bad;
    logic [11:0] as, ad;
    for (int k = 0; k < l; k++) begin
      as = s + 12'(k);
      ad = d + 12'(k);
      ref_mem[ad] = ref_mem[as];
      exp_q.push_back('{a: ad, d: ref_mem[ad]});
    end
    last = (l == 0) ? 1 : 2 * l + 1;
    @(negedge clk);
    start = 1'b1; src_addr = s; dst_addr = d; length = 13'(l);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= last + 1; c++) begin
      check($sformatf("busy_c%0d_L%0d", c, l), 32'(busy), 32'(c <= last));
      check($sformatf("done_c%0d_L%0d", c, l), 32'(done), 32'(c == last));
      if (ign && c == 3) begin
        start = 1'b1; src_addr = 12'h555; dst_addr = 12'h666; length = 13'd2;
      end
      if (ign && c == 4) start = 1'b0;
      @(negedge clk);
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    bad = 0;
    for (int k = 0; k < l; k++) begin
      ad = d + 12'(k);
      if (mem[ad] !== ref_mem[ad]) bad++;
    end
    check($sformatf("dst_region_L%0d", l), 32'(bad), 32'd0);
  endtask

  initial begin
    logic [11:0] s, d;
    int l;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_addr", 32'(ram_address), 32'd0);
    check("reset_we", 32'(ram_mem_write), 32'd0);
    check("reset_datain", 32'(ram_datain), 32'd0);
    reset = 1'b0;

    for (int k = 0; k < 4; k++) preload(12'h010 + 12'(k), 12'hA01 + 12'(k));
    run_copy(12'h010, 12'h100, 4, 1'b0);
    for (int k = 0; k < 4; k++)
      check($sformatf("basic_ram_%0d", k), 32'(mem[12'h100 + 12'(k)]), 32'(12'hA01 + 12'(k)));

    preload(12'h005, 12'h0AB);
    preload(12'h006, 12'h0CD);
    run_copy(12'h005, 12'h006, 0, 1'b0);
    check("len0_unchanged", 32'(mem[12'h006]), 32'h0CD);

    preload(12'hFFE, 12'h111); preload(12'hFFF, 12'h222);
    preload(12'h000, 12'h333); preload(12'h001, 12'h444);
    run_copy(12'hFFE, 12'h7FE, 4, 1'b0);
    check("wrap_0", 32'(mem[12'h7FE]), 32'h111);
    check("wrap_1", 32'(mem[12'h7FF]), 32'h222);
    check("wrap_2", 32'(mem[12'h800]), 32'h333);
    check("wrap_3", 32'(mem[12'h801]), 32'h444);

    preload(12'h020, 12'h5A5); preload(12'h021, 12'h0F0);
    run_copy(12'h020, 12'h021, 2, 1'b0);
    check("overlap_21", 32'(mem[12'h021]), 32'h5A5);
    check("overlap_22", 32'(mem[12'h022]), 32'h5A5);

    for (int k = 0; k < 4; k++) preload(12'h040 + 12'(k), 12'h900 + 12'(k));
    preload(12'h666, 12'h123);
    run_copy(12'h040, 12'h300, 4, 1'b1);
    check("ignored_start_dst", 32'(mem[12'h666]), 32'h123);

    for (int k = 0; k < 4; k++) preload(12'h030 + 12'(k), 12'h3C0 + 12'(k));
    preload(12'h200, 12'h777);
    @(negedge clk);
    start = 1'b1; src_addr = 12'h030; dst_addr = 12'h200; length = 13'd4;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_addr", 32'(ram_address), 32'd0);
    check("abort_we", 32'(ram_mem_write), 32'd0);
    check("abort_datain", 32'(ram_datain), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("abort_no_write", 32'(mem[12'h200]), 32'h777);
    run_copy(12'h030, 12'h200, 1, 1'b0);
    check("after_abort_ram", 32'(mem[12'h200]), 32'h3C0);

    for (int t = 0; t < 8; t++) begin
      s = 12'($urandom);
      d = (t % 3 == 0) ? s + 12'($urandom_range(0, 3)) : 12'($urandom);
      l = $urandom_range(0, 12);
      for (int k = 0; k < l; k++) preload(s + 12'(k), 12'($urandom));
      run_copy(s, d, l, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
